// File: rtl/pcpi_div_dispatch.sv
// Front end of the PCPI divider: decodes RV32M DIV/DIVU/REM/REMU, drives the divider handshake,
// and returns its result to the core. Defining DIV_CACHE_EN adds a last-result cache.
module pcpi_div_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        div_valid,
  output logic [31:0] div_insn,
  output logic [31:0] div_rs1,
  output logic [31:0] div_rs2,
  input  logic        div_ready,
  input  logic [31:0] div_rd,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             aborted;
  logic             is_div;
  logic             timeout_hit;
  logic             issue_ok;
  logic             issue_timeout;
  logic             cache_hit;
  logic [31:0]      cache_result;

  assign is_div = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) &&
                  pcpi_insn[14];
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  // Completion qualifiers for the divider handshake; div_ready outranks the timeout
  always_comb begin
    issue_ok      = 1'b0;
    issue_timeout = 1'b0;
    if (state == ISSUE) begin
      issue_ok      = div_ready && pcpi_valid && !aborted;
      issue_timeout = !div_ready && timeout_hit;
    end else begin
      issue_ok      = 1'b0;
      issue_timeout = 1'b0;
    end
  end

`ifdef DIV_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic [2:0]  cache_f3;
  logic [31:0] cache_res;

  // Last-result cache: refilled by every delivered divider result, dropped on timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_rs1   <= 32'd0;
      cache_rs2   <= 32'd0;
      cache_f3    <= 3'd0;
      cache_res   <= 32'd0;
    end else if (issue_ok) begin
      cache_valid <= 1'b1;
      cache_rs1   <= div_rs1;
      cache_rs2   <= div_rs2;
      cache_f3    <= div_insn[14:12];
      cache_res   <= div_rd;
    end else if (issue_timeout) begin
      cache_valid <= 1'b0;
    end else begin
      cache_valid <= cache_valid;
    end
  end

  // Key match against the request currently on the bus
  always_comb begin
    cache_hit    = cache_valid && (cache_rs1 == pcpi_rs1) && (cache_rs2 == pcpi_rs2) &&
                   (cache_f3 == pcpi_insn[14:12]);
    cache_result = cache_res;
  end
`else
  // No cache in this build
  always_comb begin
    cache_hit    = 1'b0;
    cache_result = 32'd0;
  end
`endif

  // Dispatch FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      aborted     <= 1'b0;
      pcpi_wr     <= 1'b0;
      pcpi_rd     <= 32'd0;
      pcpi_wait   <= 1'b0;
      pcpi_ready  <= 1'b0;
      div_valid   <= 1'b0;
      div_insn    <= 32'd0;
      div_rs1     <= 32'd0;
      div_rs2     <= 32'd0;
      err_timeout <= 1'b0;
    end else begin
      pcpi_ready  <= 1'b0;
      pcpi_wr     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pcpi_valid && is_div) begin
            div_insn <= pcpi_insn;
            div_rs1  <= pcpi_rs1;
            div_rs2  <= pcpi_rs2;
            cnt      <= '0;
            aborted  <= 1'b0;
            if (cache_hit) begin
              state      <= RESP;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              pcpi_rd    <= cache_result;
            end else begin
              state     <= ISSUE;
              div_valid <= 1'b1;
              pcpi_wait <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + CNT_ONE;
          if (!pcpi_valid) begin
            aborted <= 1'b1;
          end
          if (div_ready) begin
            div_valid <= 1'b0;
            pcpi_wait <= 1'b0;
            if (issue_ok) begin
              state      <= RESP;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              pcpi_rd    <= div_rd;
            end else begin
              // Core withdrew: the divider still finishes but its result is dropped
              state <= DRAIN;
            end
          end else if (issue_timeout) begin
            err_timeout <= 1'b1;
            div_valid   <= 1'b0;
            pcpi_wait   <= 1'b0;
            state       <= IDLE;
          end
        end
        RESP:    state <= DRAIN;
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_div_dispatch.sv
// Directed bench for pcpi_div_dispatch with a stub divider and a result scoreboard.
// Build with DIV_CACHE_EN defined to also exercise the result cache.
module tb_pcpi_div_dispatch;

  localparam logic [31:0] I_DIV  = 32'h0200_4033;
  localparam logic [31:0] I_DIVU = 32'h0200_5033;
  localparam logic [31:0] I_REM  = 32'h0200_6033;
  localparam logic [31:0] I_REMU = 32'h0200_7033;
  localparam logic [31:0] I_MUL  = 32'h0200_0033;
  localparam logic [31:0] I_XOR  = 32'h0000_4033;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        div_valid, div_ready;
  logic [31:0] div_insn, div_rs1, div_rs2, div_rd;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_insn, cur_rs1, cur_rs2;
  int stub_lat = 0;
  int stub_cnt = 0;

  always #5 clk = ~clk;

  pcpi_div_dispatch dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .div_valid(div_valid), .div_insn(div_insn), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_ready(div_ready), .div_rd(div_rd), .err_timeout(err_timeout)
  );

  // RV32M divide/remainder semantics, including divide-by-zero and overflow cases
  function automatic logic [31:0] rv_div(input logic [31:0] insn, input logic [31:0] a,
                                         input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (insn[14:12])
      3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      3'd7: return (b == 32'd0) ? a : a % b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Stub divider: answers in the stub_lat-th cycle of div_valid; stub_lat==0 never answers
  always @(posedge clk) begin
    if (reset || !div_valid) stub_cnt <= 0;
    else stub_cnt <= stub_cnt + 1;
  end
  always_comb begin
    div_ready = div_valid && (stub_lat > 0) && (stub_cnt == stub_lat - 1);
    div_rd    = div_ready ? rv_div(div_insn, div_rs1, div_rs2) : 32'hBAD0_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle protocol and scoreboard comparison against the expected-result queue
  always @(negedge clk) begin
    if (!reset) begin
      if (pcpi_wr || pcpi_ready) chk("wr_with_ready", {31'd0, pcpi_wr}, {31'd0, pcpi_ready});
      if (pcpi_ready) begin
        chk("ready_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        chk("wait_low_at_ready", {31'd0, pcpi_wait}, 32'd0);
        if (exp_q.size() > 0) chk("pcpi_rd", pcpi_rd, exp_q.pop_front());
      end
      if (div_valid) begin
        chk("div_insn", div_insn, cur_insn);
        chk("div_rs1", div_rs1, cur_rs1);
        chk("div_rs2", div_rs2, cur_rs2);
      end
    end
  end

  task automatic run_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int abort_at, input int n,
                        output int dv_n, output int dv_first, output int rdy_n,
                        output int rdy_first, output int wait_n, output int to_n,
                        output int to_first);
    stub_lat = lat;
    dv_n = 0; rdy_n = 0; wait_n = 0; to_n = 0;
    dv_first = -1; rdy_first = -1; to_first = -1;
    @(negedge clk);
    cur_insn = insn; cur_rs1 = a; cur_rs2 = b;
    pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b; pcpi_valid = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      // Operands on the bus change after accept; the latched copies must not
      if (i == 1) begin pcpi_rs1 = ~a; pcpi_rs2 = a ^ b ^ 32'h5A5A_0000; end
      if (div_valid) begin dv_n++; if (dv_first < 0) dv_first = i; end
      if (pcpi_ready) begin rdy_n++; if (rdy_first < 0) rdy_first = i; end
      if (pcpi_wait) wait_n++;
      if (err_timeout) begin to_n++; if (to_first < 0) to_first = i; end
      if (pcpi_ready || err_timeout || i == abort_at) pcpi_valid = 1'b0;
    end
    pcpi_valid = 1'b0;
  endtask

  int dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first;

  initial begin
    reset = 1'b1; pcpi_valid = 1'b0;
    pcpi_insn = 32'd0; pcpi_rs1 = 32'd0; pcpi_rs2 = 32'd0;
    cur_insn = 32'd0; cur_rs1 = 32'd0; cur_rs2 = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_wr", {31'd0, pcpi_wr}, 32'd0);
    chk("rst_rd", pcpi_rd, 32'd0);
    chk("rst_wait", {31'd0, pcpi_wait}, 32'd0);
    chk("rst_ready", {31'd0, pcpi_ready}, 32'd0);
    chk("rst_div_valid", {31'd0, div_valid}, 32'd0);
    chk("rst_div_ops", div_insn | div_rs1 | div_rs2, 32'd0);
    chk("rst_timeout", {31'd0, err_timeout}, 32'd0);
    reset = 1'b0;

    // DIV 20/3 with a 5-cycle divider
    exp_q.push_back(32'd6);
    run_op(I_DIV, 32'd20, 32'd3, 5, 0, 12, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("div_dv_cycles", 32'(dv_n), 32'd5);
    chk("div_dv_first", 32'(dv_first), 32'd1);
    chk("div_ready_cycles", 32'(rdy_n), 32'd1);
    chk("div_latency", 32'(rdy_first), 32'd6);
    chk("div_wait_cycles", 32'(wait_n), 32'd5);
    chk("div_wait_after", {31'd0, pcpi_wait}, 32'd0);

    // Non-divide instructions are ignored
    run_op(I_MUL, 32'd7, 32'd9, 5, 0, 20, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("mul_dv", 32'(dv_n), 32'd0);
    chk("mul_ready", 32'(rdy_n), 32'd0);
    chk("mul_wait", 32'(wait_n), 32'd0);
    run_op(I_XOR, 32'd7, 32'd9, 5, 0, 8, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("xor_dv", 32'(dv_n), 32'd0);

    // Divider never answers: timeout 64 cycles after div_valid rises
    run_op(I_DIV, 32'd100, 32'd7, 0, 0, 72, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("to_pulses", 32'(to_n), 32'd1);
    chk("to_delay", 32'(to_first - dv_first), 32'd64);
    chk("to_dv_cycles", 32'(dv_n), 32'd64);
    chk("to_no_ready", 32'(rdy_n), 32'd0);
    chk("to_wait_after", {31'd0, pcpi_wait}, 32'd0);

    // REM -20/3 withdrawn two cycles after accept: divider completes, result dropped
    run_op(I_REM, 32'hFFFF_FFEC, 32'd3, 5, 2, 10, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("abort_dv_cycles", 32'(dv_n), 32'd5);
    chk("abort_no_ready", 32'(rdy_n), 32'd0);
    chk("abort_rd_held", pcpi_rd, 32'd6);

    // DIVU 20/0
    exp_q.push_back(32'hFFFF_FFFF);
    run_op(I_DIVU, 32'd20, 32'd0, 3, 0, 8, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("divu0_ready", 32'(rdy_n), 32'd1);
    chk("divu0_latency", 32'(rdy_first), 32'd4);
    chk("divu0_rd_held", pcpi_rd, 32'hFFFF_FFFF);

    // Reset while the divider is busy
    stub_lat = 10;
    @(negedge clk);
    cur_insn = I_DIV; cur_rs1 = 32'd7; cur_rs2 = 32'd2;
    pcpi_insn = I_DIV; pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd2; pcpi_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, div_valid}, 32'd1);
    reset = 1'b1; pcpi_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_div_valid", {31'd0, div_valid}, 32'd0);
    chk("mid_rst_wait", {31'd0, pcpi_wait}, 32'd0);
    chk("mid_rst_ready", {31'd0, pcpi_ready}, 32'd0);
    chk("mid_rst_rd", pcpi_rd, 32'd0);
    reset = 1'b0;
    exp_q.push_back(32'h8000_0000);
    run_op(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4, 0, 8, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("ovf_ready", 32'(rdy_n), 32'd1);
    chk("ovf_latency", 32'(rdy_first), 32'd5);

`ifdef DIV_CACHE_EN
    exp_q.push_back(32'd2);
    run_op(I_REMU, 32'd20, 32'd3, 5, 0, 8, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("c_miss_dv", 32'(dv_n), 32'd5);
    exp_q.push_back(32'd2);
    run_op(I_REMU, 32'd20, 32'd3, 5, 0, 4, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("c_hit_dv", 32'(dv_n), 32'd0);
    chk("c_hit_latency", 32'(rdy_first), 32'd1);
    exp_q.push_back(32'd0);
    run_op(I_REMU, 32'd20, 32'd4, 5, 0, 8, dv_n, dv_first, rdy_n, rdy_first, wait_n, to_n, to_first);
    chk("c_key_miss_dv", 32'(dv_n), 32'd5);
    chk("c_key_miss_ready", 32'(rdy_n), 32'd1);
`endif

    repeat (2) @(negedge clk);
    chk("all_results_seen", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
